// File: rtl/ssp_ctx_engine_pkg.sv
// ssp_ctx_engine_pkg: shared states, stack geometry and constants for the context engine
package ssp_ctx_engine_pkg;
  typedef enum logic [2:0] {IDLE, RDSSP, PUSH, POP, WB, ERR} state_e;
  typedef enum logic {MODE_PUSH, MODE_POP} mode_e;
  localparam int STACK_WORDS = 3;
  localparam int STACK_BYTES = 12;
  localparam int WORD_STRIDE = 4;
  localparam logic [31:0] UNKNOW = 32'h0;
endpackage

// File: rtl/ssp_ctx_engine_if.sv
// ssp_ctx_engine_if: CP0, SSP-unit and data-memory signals of the context engine
interface ssp_ctx_engine_if #(parameter int DW = 32);
  logic exc_req, eret_req;
  logic [DW-1:0] exc_epc, exc_status, exc_cause;
  logic ssp_re, ssp_we;
  logic [DW-1:0] ssp_rdata, ssp_wdata;
  logic mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic busy, done, err;
  logic [DW-1:0] rst_epc, rst_status, rst_cause;
  modport slave (
    input exc_req, eret_req, exc_epc, exc_status, exc_cause, ssp_rdata, mem_ack, mem_rdata,
    output ssp_re, ssp_we, ssp_wdata, mem_req, mem_we, mem_addr, mem_wdata,
    output busy, done, err, rst_epc, rst_status, rst_cause
  );
  modport master (
    output exc_req, eret_req, exc_epc, exc_status, exc_cause, ssp_rdata, mem_ack, mem_rdata,
    input ssp_re, ssp_we, ssp_wdata, mem_req, mem_we, mem_addr, mem_wdata,
    input busy, done, err, rst_epc, rst_status, rst_cause
  );
endinterface

// File: rtl/ssp_ctx_addr.sv
// ssp_ctx_addr: stack word address and write-back SSP value for push/pop
module ssp_ctx_addr
  import ssp_ctx_engine_pkg::*;
#(parameter int DW = 32) (
  input  logic [DW-1:0] base,
  input  logic [1:0]    k,
  input  mode_e         mode,
  output logic [DW-1:0] addr,
  output logic [DW-1:0] ssp_next
);
  logic pop;
  logic [1:0] idx;
  logic [DW-1:0] off;
  always_comb begin
    pop = mode == MODE_POP;
    idx = pop ? k : k + 2'd1;
    off = DW'(idx) * DW'(WORD_STRIDE);
    addr = pop ? base + off : base - off;
    ssp_next = pop ? base + DW'(STACK_BYTES) : base - DW'(STACK_BYTES);
  end
endmodule

// File: rtl/ssp_dffe.sv
// ssp_dffe: enabled register with asynchronous active-high clear
module ssp_dffe #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/ssp_ctx_engine.sv
// ssp_ctx_engine: pushes/pops EPC, Status, Cause on the system stack and updates the SSP.
// Optional SSP alignment fault via SSP_ALIGN_CHECK_EN.
module ssp_ctx_engine
  import ssp_ctx_engine_pkg::*;
#(parameter int DW = 32) (
  input logic clk,
  input logic rst,
  ssp_ctx_engine_if.slave bus
);
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [1:0] k_q, k_d;
  logic [DW-1:0] base_q, epc_q, status_q, cause_q, addr, ssp_next;
  logic mem_ph, last, misalign, rd_ack, cap_ctx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      mode_q <= MODE_PUSH;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      k_q <= k_d;
    end
`ifdef SSP_ALIGN_CHECK_EN
  assign misalign = |bus.ssp_rdata[1:0];
  assign bus.err = state_q == ERR;
`else
  assign misalign = 1'b0;
  assign bus.err = 1'b0;
`endif
  assign last = k_q == 2'(STACK_WORDS - 1);
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    k_d = k_q;
    case (state_q)
      IDLE: if (bus.exc_req || bus.eret_req) begin
        state_d = RDSSP;
        mode_d = bus.exc_req ? MODE_PUSH : MODE_POP;
        k_d = '0;
      end
      RDSSP: state_d = misalign ? ERR : mode_q == MODE_POP ? POP : PUSH;
      PUSH, POP: if (bus.mem_ack) begin
        k_d = last ? 2'd0 : k_q + 2'd1;
        state_d = last ? WB : state_q;
      end
      default: state_d = IDLE;
    endcase
  end
  ssp_ctx_addr #(.DW(DW)) u_addr (.base(base_q), .k(k_q), .mode(mode_q), .addr(addr), .ssp_next(ssp_next));
  assign cap_ctx = state_q == IDLE && bus.exc_req;
  assign rd_ack = state_q == POP && bus.mem_ack;
  ssp_dffe #(.W(DW)) u_base (.clk(clk), .rst(rst), .en(state_q == RDSSP), .d(bus.ssp_rdata), .q(base_q));
  ssp_dffe #(.W(DW)) u_epc (.clk(clk), .rst(rst), .en(cap_ctx), .d(bus.exc_epc), .q(epc_q));
  ssp_dffe #(.W(DW)) u_status (.clk(clk), .rst(rst), .en(cap_ctx), .d(bus.exc_status), .q(status_q));
  ssp_dffe #(.W(DW)) u_cause (.clk(clk), .rst(rst), .en(cap_ctx), .d(bus.exc_cause), .q(cause_q));
  // pop reads come back Cause, Status, EPC
  ssp_dffe #(.W(DW)) u_rcause (.clk(clk), .rst(rst), .en(rd_ack && k_q == 2'd0), .d(bus.mem_rdata), .q(bus.rst_cause));
  ssp_dffe #(.W(DW)) u_rstatus (.clk(clk), .rst(rst), .en(rd_ack && k_q == 2'd1), .d(bus.mem_rdata), .q(bus.rst_status));
  ssp_dffe #(.W(DW)) u_repc (.clk(clk), .rst(rst), .en(rd_ack && k_q == 2'd2), .d(bus.mem_rdata), .q(bus.rst_epc));
  assign mem_ph = state_q == PUSH || state_q == POP;
  assign bus.mem_req = mem_ph;
  assign bus.mem_we = state_q == PUSH;
  assign bus.mem_addr = mem_ph ? addr : DW'(UNKNOW);
  assign bus.mem_wdata = state_q != PUSH ? DW'(UNKNOW) :
                         k_q == 2'd0 ? epc_q : k_q == 2'd1 ? status_q : k_q == 2'd2 ? cause_q : DW'(UNKNOW);
  assign bus.ssp_re = state_q == RDSSP;
  assign bus.ssp_we = state_q == WB;
  assign bus.ssp_wdata = state_q == WB ? ssp_next : DW'(UNKNOW);
  assign bus.done = state_q == WB;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_ssp_ctx_engine.sv
// tb_ssp_ctx_engine: random and directed push/pop runs checked against a stack reference model
module tb_ssp_ctx_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ssp_ctx_engine_if #(.DW(32)) bus();
  ssp_ctx_engine #(.DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] pushed[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] bg(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bg(a);
  endfunction
  task automatic run_op(input bit push, input logic [31:0] ssp, epc, st, ca,
                        input int lat, input bit noise, input int rst_at);
    logic [31:0] a_q[$];
    logic [31:0] d_q[$];
    bit w_q[$];
    logic [31:0] words[3];
    logic [31:0] wd = '0;
    logic [31:0] prev_a = '0;
    int done_cyc = -1, err_cyc = -1, re_cyc = -1, idle_cyc = -1;
    int we_cnt = 0, re_cnt = 0, done_cnt = 0, both = 0, cnt = 0, hold_bad = 0, exp_done;
    bit exp_err;
    @(negedge clk);
    bus.exc_req = push;
    bus.eret_req = !push || noise;
    bus.exc_epc = epc;
    bus.exc_status = st;
    bus.exc_cause = ca;
    bus.ssp_rdata = ssp;
    @(posedge clk);
    for (int c = 1; c < 300 && idle_cyc < 0; c++) begin
      @(negedge clk);
      bus.exc_req = 1'b0;
      bus.eret_req = noise && c >= 2 && c <= 4;
      bus.mem_ack = 1'b0;
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_ctl", 32'({bus.ssp_re, bus.ssp_we, bus.mem_req, bus.mem_we, bus.busy, bus.done, bus.err}), 32'h0);
        chk("rst_bus", bus.mem_addr | bus.mem_wdata | bus.ssp_wdata, 32'h0);
        chk("rst_ctx", bus.rst_epc | bus.rst_status | bus.rst_cause, 32'h0);
        repeat (2) begin
          @(negedge clk);
          if (bus.ssp_we) we_cnt++;
        end
        rst = 1'b0;
        chk("rst_no_sspwe", 32'(we_cnt), 32'h0);
        return;
      end
      if (bus.ssp_re) begin re_cnt++; re_cyc = c; end
      if (bus.ssp_we) begin we_cnt++; wd = bus.ssp_wdata; end
      if (bus.ssp_re && bus.ssp_we) both++;
      if (bus.done) begin done_cnt++; done_cyc = c; end
      if (bus.err) err_cyc = c;
      if (!bus.busy) idle_cyc = c;
      if (bus.mem_req) begin
        if (cnt > 0 && bus.mem_addr !== prev_a) hold_bad++;
        prev_a = bus.mem_addr;
        cnt++;
        if (cnt > lat) begin
          bus.mem_ack = 1'b1;
          cnt = 0;
          a_q.push_back(bus.mem_addr);
          w_q.push_back(bus.mem_we);
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            d_q.push_back(bus.mem_wdata);
          end else begin
            bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : bg(bus.mem_addr);
            d_q.push_back(bus.mem_rdata);
          end
        end
      end
    end
    bus.mem_ack = 1'b0;
    bus.eret_req = 1'b0;
`ifdef SSP_ALIGN_CHECK_EN
    exp_err = ssp[1:0] != 2'b00;
`else
    exp_err = 1'b0;
`endif
    chk("ssp_re_cycle", 32'(re_cyc), 32'd1);
    chk("ssp_re_count", 32'(re_cnt), 32'd1);
    chk("re_we_overlap", 32'(both), 32'd0);
    chk("addr_hold", 32'(hold_bad), 32'd0);
    if (exp_err) begin
      chk("err_cycle", 32'(err_cyc), 32'd2);
      chk("err_no_mem", 32'(a_q.size()), 32'd0);
      chk("err_no_sspwe", 32'(we_cnt), 32'd0);
      chk("err_idle", 32'(idle_cyc), 32'd3);
      return;
    end
    exp_done = 2 + 3 * (lat + 1);
    words = '{epc, st, ca};
    chk("no_err", 32'(err_cyc), 32'hFFFF_FFFF);
    chk("n_access", 32'(a_q.size()), 32'd3);
    for (int k = 0; k < 3 && k < a_q.size(); k++) begin
      logic [31:0] ea;
      ea = push ? ssp - 32'(4 * (k + 1)) : ssp + 32'(4 * k);
      chk($sformatf("addr%0d", k), a_q[k], ea);
      chk($sformatf("we%0d", k), 32'(w_q[k]), 32'(push));
      if (push) chk($sformatf("wdata%0d", k), d_q[k], words[k]);
    end
    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("busy_fall", 32'(idle_cyc), 32'(exp_done + 1));
    chk("sspwe_count", 32'(we_cnt), 32'd1);
    chk("ssp_wdata", wd, push ? ssp - 32'd12 : ssp + 32'd12);
    if (push) begin
      for (int k = 0; k < 3; k++) ref_mem[ssp - 32'(4 * (k + 1))] = words[k];
    end else begin
      chk("rst_cause", bus.rst_cause, ref_rd(ssp));
      chk("rst_status", bus.rst_status, ref_rd(ssp + 32'd4));
      chk("rst_epc", bus.rst_epc, ref_rd(ssp + 32'd8));
    end
  endtask
  initial begin
    int extra;
    bus.exc_req = 1'b0;
    bus.eret_req = 1'b0;
    bus.exc_epc = '0;
    bus.exc_status = '0;
    bus.exc_cause = '0;
    bus.ssp_rdata = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", 32'({bus.ssp_re, bus.ssp_we, bus.mem_req, bus.mem_we, bus.busy, bus.done, bus.err}), 32'h0);
    chk("reset_bus", bus.mem_addr | bus.mem_wdata | bus.ssp_wdata, 32'h0);
    chk("reset_ctx", bus.rst_epc | bus.rst_status | bus.rst_cause, 32'h0);
    rst = 1'b0;
    run_op(1'b1, 32'h0000_1000, 32'hBFC0_0180, 32'h11, 32'h24, 0, 1'b0, 0);
    run_op(1'b0, 32'h0000_0FF4, '0, '0, '0, 2, 1'b0, 0);
    chk("pop_epc_value", bus.rst_epc, 32'hBFC0_0180);
    run_op(1'b1, 32'h0000_3000, $urandom, $urandom, $urandom, 1, 1'b1, 0);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    chk("ignored_eret", 32'(extra), 32'd0);
    chk("idle_after_ignore", 32'(bus.busy), 32'd0);
    run_op(1'b1, 32'h0000_0008, $urandom, $urandom, $urandom, 0, 1'b0, 0);
    run_op(1'b1, 32'h0000_1002, $urandom, $urandom, $urandom, 0, 1'b0, 0);
    run_op(1'b1, 32'h0000_2000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 5, 1'b0, 9);
    ref_mem[32'h0000_1FFC] = 32'hCAFE_0001;
    chk("rst_partial_mem", 32'(mem.exists(32'h0000_1FF8)), 32'd0);
    @(negedge clk);
    chk("rst_release_idle", 32'(bus.busy), 32'd0);
    run_op(1'b0, 32'h0000_1FF4, '0, '0, '0, 0, 1'b0, 0);
    for (int i = 0; i < 24; i++) begin
      bit p;
      logic [31:0] sp;
      p = pushed.size() == 0 || $urandom_range(0, 1) == 1;
      if (p) begin
        sp = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) sp[1:0] = 2'($urandom_range(1, 3));
        run_op(1'b1, sp, $urandom, $urandom, $urandom, $urandom_range(0, 3), 1'b0, 0);
        pushed.push_back(sp - 32'd12);
      end else begin
        sp = $urandom_range(0, 3) == 0 ? $urandom & 32'hFFFF_FFFC : pushed.pop_back();
        run_op(1'b0, sp, '0, '0, '0, $urandom_range(0, 3), 1'b0, 0);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
